// File: rtl/padd_scheduler.sv
// Round-robin front end sharing one fixed-latency pipelined 32-bit adder among NREQ requesters.
// Build option PADD_SCHED_STATS_EN adds the stat_issued / stat_blocked counters.
module padd_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned LAT        = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [32*NREQ-1:0]      req_a,
  input  logic [32*NREQ-1:0]      req_b,
  input  logic [NREQ-1:0]         req_ci,
  output logic [31:0]             add_a,
  output logic [31:0]             add_b,
  output logic                    add_ci,
  input  logic [31:0]             add_s,
  input  logic                    add_co,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [31:0]             rsp_sum,
  output logic                    rsp_co
`ifdef PADD_SCHED_STATS_EN
  ,
  output logic [31:0]             stat_issued,
  output logic [31:0]             stat_blocked
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] next_ptr;
  logic           found;
  logic           credit_ok;
  logic           grant;
  logic [CW:0]    occupancy;

  logic [CW-1:0]  in_flight;
  logic [CW-1:0]  fifo_count;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  logic [LAT-1:0] sr_vld;
  logic [IDW-1:0] sr_id [LAT];

  logic [31:0]    mem_sum [FIFO_DEPTH];
  logic           mem_co  [FIFO_DEPTH];
  logic [IDW-1:0] mem_id  [FIFO_DEPTH];

  logic           push;
  logic           pop;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  // Credit uses registered counts only, so a same-cycle pop frees space one cycle later.
  always_comb begin
    occupancy = {1'b0, in_flight} + {1'b0, fifo_count};
    credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);
    grant     = found & credit_ok & ~Reset;
    next_ptr  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_ci    = 1'b0;
    if (grant) begin
      req_ready = NREQ'(1) << grant_id;
      add_a     = req_a[32*grant_id +: 32];
      add_b     = req_b[32*grant_id +: 32];
      add_ci    = req_ci[grant_id];
    end
  end

  assign push = sr_vld[LAT-1];
  assign pop  = rsp_valid & rsp_ready;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sr_vld <= '0;
    end else begin
      sr_vld[0] <= grant;
      for (int unsigned i = 1; i < LAT; i++) begin
        sr_vld[i] <= sr_vld[i-1];
      end
    end
  end

  always_ff @(posedge Clock) begin
    sr_id[0] <= grant_id;
    for (int unsigned i = 1; i < LAT; i++) begin
      sr_id[i] <= sr_id[i-1];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rr_ptr     <= '0;
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_sum[i] <= '0;
        mem_co[i]  <= 1'b0;
        mem_id[i]  <= '0;
      end
    end else begin
      if (grant) begin
        rr_ptr <= next_ptr;
      end
      if (push) begin
        mem_sum[wr_ptr] <= add_s;
        mem_co[wr_ptr]  <= add_co;
        mem_id[wr_ptr]  <= sr_id[LAT-1];
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      in_flight  <= in_flight + CW'(grant) - CW'(push);
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_sum   = mem_sum[rd_ptr];
  assign rsp_co    = mem_co[rd_ptr];
  assign rsp_id    = mem_id[rd_ptr];

`ifdef PADD_SCHED_STATS_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stat_issued  <= '0;
      stat_blocked <= '0;
    end else begin
      if (grant) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if ((|req_valid) && !credit_ok) begin
        stat_blocked <= stat_blocked + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/padd_scheduler.md
Name: padd_scheduler

Overview:
Round-robin scheduler sharing one 32-bit pipelined adder (fixed LAT-cycle latency, no valid/stall inputs) between NREQ requesters. Tracks each issued operation with a valid/ID shift register matching the adder depth. Captures results into a response FIFO. Uses credit-based issue so that results leaving the non-stallable pipeline always have FIFO space.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 4, adder latency in clock edges from operand presentation to S/CO valid
FIFO_DEPTH, 8, response FIFO entries (power of 2, >= LAT)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester operation request
req_ready  out  NREQ  per-requester grant; at most one bit high
req_a  in  32*NREQ  operand A, requester i at [32*i+31:32*i]
req_b  in  32*NREQ  operand B, same packing
req_ci  in  NREQ  carry-in per requester
add_a  out  32  to adder A
add_b  out  32  to adder B
add_ci  out  1  to adder CI
add_s  in  32  from adder S
add_co  in  1  from adder CO
rsp_valid  out  1  FIFO head valid
rsp_ready  in  1  consumer accepts head
rsp_id  out  $clog2(NREQ)  requester index of head result
rsp_sum  out  32  head sum
rsp_co  out  1  head carry-out

Behaviour:
- Reset (Clock edge with Reset=1): rr_ptr=0, shift register valid bits cleared, FIFO empty, in_flight=0. Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_co=0, add_a=0, add_b=0, add_ci=0.
- Reset mid-operation: all in-flight ops and FIFO contents are discarded. Adder contents emerging after reset are ignored because their valid bits are cleared.
- Credit: issue is allowed when in_flight + fifo_count < FIFO_DEPTH. in_flight counts valid bits in the shift register.
- Arbitration (combinational per cycle): search req_valid starting at rr_ptr, wrapping modulo NREQ. The first set bit g gets req_ready[g]=1, but only when credit is available. The handshake completes when req_valid[g] & req_ready[g]. On that edge rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr is unchanged.
- req_ready depends combinationally on req_valid. Requesters hold req_valid and operands stable until granted.
- Issue: in the grant cycle t, add_a/add_b/add_ci are driven from requester g. With no grant they are driven 0. At edge t, {1,g} enters stage 0 of the LAT-deep valid/ID shift register.
- Capture: the valid/ID entry reaches the last stage in cycle t+LAT, when add_s/add_co belong to that op. {id, add_s, add_co} is pushed into the FIFO at the end of cycle t+LAT. rsp_valid is 1 no earlier than cycle t+LAT+1.
- Minimum request-to-response latency is LAT+1 cycles. Throughput is one op per cycle while credit allows.
- FIFO: rsp_* show the head (registered storage). Pop when rsp_valid & rsp_ready. Push and pop in the same cycle are both honoured, including when the FIFO is full or empty-plus-push.
- Overflow is impossible by construction, because credit includes in_flight. An empty FIFO does not bypass the push to the outputs in the same cycle.
- Ordering: responses appear in issue order, globally.
- Credit boundary: when in_flight + fifo_count = FIFO_DEPTH, all req_ready=0. A pop in the same cycle does not restore credit until the next cycle, so credit uses registered counts only.
- Widths: fifo_count and in_flight are $clog2(FIFO_DEPTH)+1 bits. Sums wrap modulo 2^32 as the adder does. CO is passed unchanged.

Optional Feature:
PADD_SCHED_STATS_EN
- Defined: adds outputs stat_issued (32 bits) and stat_blocked (32 bits), both reset to 0.
  - stat_issued increments on each grant.
  - stat_blocked increments on each cycle with any req_valid high and no grant because credit is exhausted.
  - Both counters wrap at 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single op: req0 issues A=0x0000_00FF, B=0x0000_0001, CI=0 in cycle 10. Expect rsp_valid in cycle 15 with rsp_id=0, sum=0x0000_0100, co=0.
- Carry out: A=0xFFFF_FFFF, B=0x0, CI=1 -> sum=0x0000_0000, co=1.
- Round-robin: all 4 requesters hold req_valid with rsp_ready=1. Expect grant order 0,1,2,3,0,... with one grant per cycle and responses in that order, ids matching.
- Credit stall: rsp_ready=0, all requesters valid. Expect exactly 8 grants, then req_ready=0 persistently. Then assert rsp_ready=1: one result popped per cycle, and grants resume the cycle after the first pop.
- Reset mid-flight: issue 3 ops, assert Reset on the cycle after the 3rd grant. Expect rsp_valid=0 for the following 10 cycles with no requests, and rr_ptr=0 (next request from req2 is granted immediately).
- Stats (PADD_SCHED_STATS_EN): run the credit-stall scenario for 20 cycles. Expect stat_issued=8 and stat_blocked=12.
